// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with long-latency destination scoreboard.
// Two writeback sources share one write port under round-robin fairness;
// busy bits track registers owed by long-latency units so decode can stall.
module rf_wb_arbiter #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_wa,
    input  logic [DW-1:0] req0_wd,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_wa,
    input  logic [DW-1:0] req1_wd,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_wa,
    output logic          iss_ready,
    input  logic [AW-1:0] chk_ra0,
    input  logic [AW-1:0] chk_ra1,
    output logic          chk_busy0,
    output logic          chk_busy1,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic          sb_err
);

    localparam int unsigned NREG = 2 ** AW;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            rr_last;
    logic            rr_last_nxt;
    logic            sb_err_nxt;
    logic            gnt0;
    logic            gnt1;
    logic            iss_set;

    // Round-robin grant; everything is held off while reset is asserted
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            gnt0 = req0_valid && (!req1_valid || rr_last);
            gnt1 = req1_valid && (!req0_valid || !rr_last);
        end
    end

    // Write port mux, handshakes and hazard check ports
    always_comb begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        rf_we      = 1'b0;
        rf_wa      = '0;
        rf_wd      = '0;
        if (gnt0) begin
            rf_we = (req0_wa != '0);
            rf_wa = req0_wa;
            rf_wd = req0_wd;
        end else if (gnt1) begin
            rf_we = (req1_wa != '0);
            rf_wa = req1_wa;
            rf_wd = req1_wd;
        end
        iss_ready = rst_n && ((iss_wa == '0) || !busy[iss_wa]);
        iss_set   = iss_valid && iss_ready && (iss_wa != '0);
        // A clearing req1 write is forwarded so decode sees the bypassed value
        chk_busy0 = rst_n && busy[chk_ra0] && (chk_ra0 != '0)
                    && !(gnt1 && (req1_wa == chk_ra0));
        chk_busy1 = rst_n && busy[chk_ra1] && (chk_ra1 != '0)
                    && !(gnt1 && (req1_wa == chk_ra1));
    end

    // Next-state for scoreboard, round-robin pointer and sticky error
    always_comb begin
        busy_nxt    = busy;
        rr_last_nxt = rr_last;
        sb_err_nxt  = sb_err;
        if (gnt0) begin
            rr_last_nxt = 1'b0;
        end
        if (gnt1) begin
            rr_last_nxt = 1'b1;
            if ((req1_wa != '0) && !busy[req1_wa]) begin
                sb_err_nxt = 1'b1;
            end
        end
        if (iss_set) begin
            busy_nxt[iss_wa] = 1'b1;
        end
        if (gnt1) begin
            busy_nxt[req1_wa] = 1'b0;
        end
        busy_nxt[0] = 1'b0;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= '0;
            rr_last <= 1'b1;
            sb_err  <= 1'b0;
        end else begin
            busy    <= busy_nxt;
            rr_last <= rr_last_nxt;
            sb_err  <= sb_err_nxt;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration, write port, scoreboard, reset.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_wa;
    logic [31:0] req0_wd;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_wa;
    logic [31:0] req1_wd;
    logic        iss_valid;
    logic [4:0]  iss_wa;
    logic        iss_ready;
    logic [4:0]  chk_ra0;
    logic [4:0]  chk_ra1;
    logic        chk_busy0;
    logic        chk_busy1;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        sb_err;

    int errors = 0;
    int checks = 0;

    rf_wb_arbiter #(.AW(5), .DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_wa    (req0_wa),
        .req0_wd    (req0_wd),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_wa    (req1_wa),
        .req1_wd    (req1_wd),
        .iss_valid  (iss_valid),
        .iss_wa     (iss_wa),
        .iss_ready  (iss_ready),
        .chk_ra0    (chk_ra0),
        .chk_ra1    (chk_ra1),
        .chk_busy0  (chk_busy0),
        .chk_busy1  (chk_busy1),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .sb_err     (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Move to the next falling edge, then let combinational outputs settle
    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic grant_chk(input string tag, input logic r0, input logic r1);
        check({tag, ".r0"}, 32'(req0_ready), 32'(r0));
        check({tag, ".r1"}, 32'(req1_ready), 32'(r1));
    endtask

    task automatic port_chk(input string tag, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd);
        check({tag, ".we"}, 32'(rf_we), 32'(we));
        check({tag, ".wa"}, 32'(rf_wa), 32'(wa));
        check({tag, ".wd"}, rf_wd, wd);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_wa = 5'd3; req0_wd = 32'h11;
        req1_valid = 1'b0; req1_wa = '0;   req1_wd = '0;
        iss_valid = 1'b1;  iss_wa = '0;
        chk_ra0 = '0;      chk_ra1 = '0;

        // Reset holds everything off even with requests present
        next_cyc(); settle();
        grant_chk("rst", 1'b0, 1'b0);
        port_chk("rst", 1'b0, 5'd0, 32'h0);
        check("rst.iss_ready", 32'(iss_ready), 32'd0);
        check("rst.sb_err", 32'(sb_err), 32'd0);
        iss_valid = 1'b0;

        // Single req0 write, zero latency to the port
        next_cyc(); rst_n = 1'b1; settle();
        grant_chk("single0", 1'b1, 1'b0);
        port_chk("single0", 1'b1, 5'd3, 32'h11);

        // Single req1 write to a non-busy register (flags sb_err next cycle)
        next_cyc(); req0_valid = 1'b0; req1_valid = 1'b1; req1_wa = 5'd4; req1_wd = 32'h22; settle();
        grant_chk("single1", 1'b0, 1'b1);
        port_chk("single1", 1'b1, 5'd4, 32'h22);
        check("single1.sb_err_same", 32'(sb_err), 32'd0);
        next_cyc(); req1_valid = 1'b0; settle();
        check("single1.sb_err_next", 32'(sb_err), 32'd1);

        // Reset pulse clears sb_err; contention then starts with req0
        rst_n = 1'b0; settle();
        check("rst2.sb_err", 32'(sb_err), 32'd0);
        next_cyc(); rst_n = 1'b1;
        req0_valid = 1'b1; req0_wa = 5'd1; req0_wd = 32'hA;
        req1_valid = 1'b1; req1_wa = 5'd0; req1_wd = 32'hB; settle();
        grant_chk("cont1", 1'b1, 1'b0);
        port_chk("cont1", 1'b1, 5'd1, 32'hA);
        next_cyc(); req0_wa = 5'd2; req0_wd = 32'hC; settle();
        grant_chk("cont2", 1'b0, 1'b1);
        port_chk("cont2", 1'b0, 5'd0, 32'hB);
        next_cyc(); req1_wd = 32'hD; settle();
        grant_chk("cont3", 1'b1, 1'b0);
        port_chk("cont3", 1'b1, 5'd2, 32'hC);
        next_cyc(); req0_wa = 5'd6; req0_wd = 32'hE; settle();
        grant_chk("cont4", 1'b0, 1'b1);
        port_chk("cont4", 1'b0, 5'd0, 32'hD);
        next_cyc(); settle();
        grant_chk("cont5", 1'b1, 1'b0);
        check("cont.sb_err", 32'(sb_err), 32'd0);

        // Scoreboard: issue x7, stall, second issue blocked, clear with forward
        next_cyc(); req0_valid = 1'b0; req1_valid = 1'b0;
        iss_valid = 1'b1; iss_wa = 5'd7; chk_ra0 = 5'd7; settle();
        check("sb.iss_ready0", 32'(iss_ready), 32'd1);
        check("sb.busy_before", 32'(chk_busy0), 32'd0);
        next_cyc(); settle();
        check("sb.busy_set", 32'(chk_busy0), 32'd1);
        check("sb.iss_blocked", 32'(iss_ready), 32'd0);
        next_cyc(); iss_valid = 1'b0;
        req1_valid = 1'b1; req1_wa = 5'd7; req1_wd = 32'h77; settle();
        grant_chk("sb.clr", 1'b0, 1'b1);
        check("sb.busy_fwd", 32'(chk_busy0), 32'd0);
        check("sb.iss_still", 32'(iss_ready), 32'd0);
        next_cyc(); req1_valid = 1'b0; settle();
        check("sb.iss_free", 32'(iss_ready), 32'd1);
        check("sb.busy_clr", 32'(chk_busy0), 32'd0);
        check("sb.sb_err", 32'(sb_err), 32'd0);

        // x0 handling
        next_cyc(); iss_valid = 1'b1; iss_wa = 5'd0;
        req0_valid = 1'b1; req0_wa = 5'd0; req0_wd = 32'h55; chk_ra1 = 5'd0; settle();
        check("x0.iss_ready", 32'(iss_ready), 32'd1);
        grant_chk("x0", 1'b1, 1'b0);
        check("x0.we", 32'(rf_we), 32'd0);
        check("x0.busy1", 32'(chk_busy1), 32'd0);
        next_cyc(); iss_valid = 1'b0; req0_valid = 1'b0; chk_ra0 = 5'd0; settle();
        check("x0.busy0_after", 32'(chk_busy0), 32'd0);

        // Error on unowed req1 write, then sticky across a legal write
        next_cyc(); req1_valid = 1'b1; req1_wa = 5'd9; req1_wd = 32'h99;
        iss_valid = 1'b1; iss_wa = 5'd10; settle();
        grant_chk("err", 1'b0, 1'b1);
        port_chk("err", 1'b1, 5'd9, 32'h99);
        check("err.same", 32'(sb_err), 32'd0);
        // Legal clear of x10 alongside a set of x5
        next_cyc(); req1_wa = 5'd10; req1_wd = 32'hAA; iss_wa = 5'd5; settle();
        check("err.next", 32'(sb_err), 32'd1);
        check("err.iss5", 32'(iss_ready), 32'd1);
        next_cyc(); req1_valid = 1'b0; iss_valid = 1'b0;
        chk_ra0 = 5'd5; chk_ra1 = 5'd10; settle();
        check("err.sticky", 32'(sb_err), 32'd1);
        check("setclr.busy5", 32'(chk_busy0), 32'd1);
        check("setclr.busy10", 32'(chk_busy1), 32'd0);

        // Mid-operation reset with busy[5] set and both requests pending
        next_cyc(); req0_valid = 1'b1; req0_wa = 5'd11; req0_wd = 32'hB1; settle();
        grant_chk("mr.pre0", 1'b1, 1'b0);
        next_cyc(); req1_valid = 1'b1; req1_wa = 5'd12; req1_wd = 32'hC1; settle();
        grant_chk("mr.pre1", 1'b0, 1'b1);
        #1; rst_n = 1'b0; #1;
        grant_chk("mr.rst", 1'b0, 1'b0);
        check("mr.we", 32'(rf_we), 32'd0);
        check("mr.iss", 32'(iss_ready), 32'd0);
        check("mr.chk0", 32'(chk_busy0), 32'd0);
        check("mr.sb_err", 32'(sb_err), 32'd0);
        next_cyc(); rst_n = 1'b1; settle();
        grant_chk("mr.post", 1'b1, 1'b0);
        port_chk("mr.post", 1'b1, 5'd11, 32'hB1);
        check("mr.busy5", 32'(chk_busy0), 32'd0);

        next_cyc(); req0_valid = 1'b0; req1_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and scoreboard for the 32x32 register file: merges two writeback sources onto the file's single write port (rf_we/rf_wa/rf_wd) with round-robin fairness. It also tracks registers owed by long-latency units (e.g. divider, load unit) so decode can stall on RAW and WAW hazards. It sits between the writeback stage and the register file, beside decode.

## Interface
- AW, 5, register address width (32 registers; x0 hardwired zero)
- DW, 32, data width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  pipeline writeback request
- req0_ready  out  1  req0 accepted this cycle
- req0_wa  in  AW  req0 destination
- req0_wd  in  DW  req0 data
- req1_valid  in  1  long-latency unit writeback request
- req1_ready  out  1  req1 accepted this cycle
- req1_wa  in  AW  req1 destination
- req1_wd  in  DW  req1 data
- iss_valid  in  1  decode issuing a long-latency op
- iss_wa  in  AW  its destination
- iss_ready  out  1  issue permitted (destination not already owed)
- chk_ra0, chk_ra1  in  AW  decode source addresses
- chk_busy0, chk_busy1  out  1  source is owed; decode must stall
- rf_we  out  1  register file write enable
- rf_wa  out  AW  register file write address
- rf_wd  out  DW  register file write data
- sb_err  out  1  sticky: req1 wrote a register not marked busy

## Operation
- State:
  - busy[31:0], reset 0; busy[0] is never set.
  - rr_last (1 bit, index of last granted requester), reset 1, so req0 wins the first contention.
  - sb_err, reset 0.
- Arbitration (combinational from current state and inputs):
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the requester that is not rr_last.
  - reqN_ready = grant==N. The loser's ready is 0 and it must hold valid/wa/wd stable.
  - On any handshake, rr_last <= granted index.
- Write port:
  - rf_wa/rf_wd = the granted request's fields.
  - rf_we = handshake && wa!=0.
  - A request to x0 is still consumed (ready=1) and updates rr_last, but rf_we=0.
  - No grant: rf_we=0, rf_wa=0, rf_wd=0.
- Scoreboard set:
  - iss_ready = (iss_wa==0) || !busy[iss_wa].
  - iss_valid && iss_ready && iss_wa!=0 sets busy[iss_wa].
- Scoreboard clear:
  - A req1 handshake clears busy[req1_wa]; req0 never clears.
  - If req1 handshakes with req1_wa!=0 and busy[req1_wa]==0, sb_err <= 1 (sticky until reset).
- Simultaneous set and clear on different registers: both take effect. The same register cannot be set and cleared in one cycle, because iss_ready=0 while it is busy.
- Check ports: chk_busyK = busy[chk_raK] && chk_raK!=0 && !(req1 handshake this cycle && req1_wa==chk_raK). The forward-clear matches the register file's same-cycle write bypass.
- Reset (any time, including mid-arbitration): busy, rr_last and sb_err take their reset values immediately. While rst_n=0, req0_ready=req1_ready=iss_ready=0, rf_we=0 and chk_busy*=0. In-flight requests are not consumed; requesters re-present after reset.

## Timing
- Grant, ready and rf_* outputs are combinational in the request cycle: zero-cycle latency to the write port. The register file commits at the next rising edge.
- busy, rr_last and sb_err update on the rising edge after the handshake.
- chk_busy drops in the same cycle as the clearing req1 handshake. iss_ready for that register rises the following cycle.
- Sustained contention alternates grants every cycle; each requester waits at most 1 cycle.
- No combinational path from any ready output back to a valid input.

## Test plan
- Reset then single writes: req0 (wa=3, wd=0x11) -> req0_ready=1, rf_we=1, rf_wa=3, rf_wd=0x11 same cycle. Next, req1 alone (wa=4) -> granted.
- Contention: both valid for 4 cycles right after reset -> grants 0,1,0,1. The loser's ready stays 0 and its data is held. rr_last ends at 1.
- Scoreboard: issue wa=7 -> busy[7]=1 and chk_ra0=7 gives chk_busy0=1 next cycle. A second issue wa=7 sees iss_ready=0. req1 writes wa=7 -> chk_busy0=0 in the same cycle and iss_ready=1 the cycle after.
- x0 handling: issue wa=0 -> iss_ready=1, busy unchanged. req0 wa=0 -> ready=1, rf_we=0. chk_ra1=0 -> chk_busy1=0.
- Error: req1 writes wa=9 while busy[9]=0 -> sb_err=1 next cycle and stays 1 across later legal writes until rst_n pulses low.
- Mid-operation reset: busy[5]=1 and both requests pending, assert rst_n=0 between clock edges -> busy clears immediately, all readies and rf_we go 0. After release, both still valid -> req0 granted first.
